// File: rtl/alu8_seq.sv
// ---------------------------------------------------------------------------
// alu8_seq
//
// Purpose:
//   Sequences an 8-bit operation through one external 4-bit ALU in two
//   nibble passes (LO then HI), chaining the carry between passes when the
//   command is arithmetic. The 8-bit result is written back into an
//   accumulator together with zero/carry/sign flags, and a one-cycle done
//   pulse marks the result as valid.
//
// Parameters:
//   ARITH_L   - value of the command's l bit that selects the ALU adder path
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-low reset
//   start     - command request, only looked at while idle
//   cmd[2:0]  - {l, aluop[1:0]} applied to both nibble passes
//   cin       - carry-in for the low-nibble pass
//   use_acc   - 1: A operand is the accumulator, 0: A operand is opa
//   opa, opb  - 8-bit operands
//   busy      - high while a command is in flight (LO, HI, DONE)
//   done      - one-cycle pulse when acc and flags hold the new result
//   acc       - accumulator / result register
//   zf/cf/sf  - zero, carry and sign flags of the last completed command
//   alu_a/b   - nibble operands driven to the external ALU
//   alu_cin   - carry-in driven to the external ALU
//   alu_op    - operation select driven to the external ALU
//   alu_l     - logic/arith select driven to the external ALU
//   alu_r     - ALU nibble result (combinational in the same cycle)
//   alu_cout  - ALU carry out
//   alu_zero  - ALU nibble-is-zero
//   alu_sign  - ALU nibble MSB
// ---------------------------------------------------------------------------
module alu8_seq #(
  parameter logic ARITH_L = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cmd,
  input  logic       cin,
  input  logic       use_acc,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic       busy,
  output logic       done,
  output logic [7:0] acc,
  output logic       zf,
  output logic       cf,
  output logic       sf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [1:0] alu_op,
  output logic       alu_l,
  input  logic [3:0] alu_r,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;

  // Operands and command captured at the accepting edge
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] cmd_q;
  logic       cin_q;

  // Low-pass results held across the HI pass
  logic [3:0] res_lo_q;
  logic       carry_q;
  logic       lo_zero_q;

  // Architectural outputs
  logic [7:0] acc_q;
  logic       zf_q;
  logic       cf_q;
  logic       sf_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] a_sel;
  logic       is_arith;

  // The accumulator is only read here while idle, so the value sampled is
  // always the one present at the accepting edge.
  assign a_sel    = use_acc ? acc_q : opa;

  // Carry chaining and carry reporting only make sense on the adder path.
  assign is_arith = (cmd_q[2] == ARITH_L);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LO : IDLE;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The external ALU sees latched values only, so input changes while busy
  // cannot reach it. Outside the two passes everything is parked at zero.
  always_comb begin
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_cin = 1'b0;
    alu_op  = 2'd0;
    alu_l   = 1'b0;
    case (state_q)
      LO: begin
        alu_a   = a_q[3:0];
        alu_b   = b_q[3:0];
        alu_cin = cin_q;
        alu_op  = cmd_q[1:0];
        alu_l   = cmd_q[2];
      end
      HI: begin
        alu_a   = a_q[7:4];
        alu_b   = b_q[7:4];
        alu_cin = is_arith & carry_q;
        alu_op  = cmd_q[1:0];
        alu_l   = cmd_q[2];
      end
      default: ;
    endcase
  end

  // FSM with registered busy/done and result write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      cmd_q     <= 3'd0;
      cin_q     <= 1'b0;
      res_lo_q  <= 4'd0;
      carry_q   <= 1'b0;
      lo_zero_q <= 1'b0;
      acc_q     <= 8'd0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      sf_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= a_sel;
            b_q    <= opb;
            cmd_q  <= cmd;
            cin_q  <= cin;
            busy_q <= 1'b1;
          end
        end
        LO: begin
          res_lo_q  <= alu_r;
          carry_q   <= alu_cout;
          lo_zero_q <= alu_zero;
        end
        HI: begin
          acc_q  <= {alu_r, res_lo_q};
          zf_q   <= alu_zero & lo_zero_q;
          sf_q   <= alu_sign;
          cf_q   <= is_arith & alu_cout;
          done_q <= 1'b1;
        end
        DONE: begin
          // busy drops with done so a new start is seen on the next edge
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign acc  = acc_q;
  assign zf   = zf_q;
  assign cf   = cf_q;
  assign sf   = sf_q;

endmodule
